// File: rtl/loteria_emissor_if.sv
// loteria_emissor_if: ticket/game handshake bundle between the emitter and its user
interface loteria_if;
    logic        start;
    logic        quick_pick;
    logic [19:0] ticket;
    logic [3:0]  num;
    logic        insert;
    logic        finish;
    logic        win_in;
    logic [1:0]  premio_in;
    logic        busy;
    logic        done;
    logic        win_out;
    logic [1:0]  premio_out;
    logic        err_bcd;
    modport master (
        output start, quick_pick, ticket, win_in, premio_in,
        input  num, insert, finish, busy, done, win_out, premio_out, err_bcd
    );
    modport slave (
        input  start, quick_pick, ticket, win_in, premio_in,
        output num, insert, finish, busy, done, win_out, premio_out, err_bcd
    );
endinterface

// File: rtl/loteria_emissor.sv
// loteria_emissor: sends a five-digit ticket to the game, then captures the result
module loteria_emissor #(
    parameter int          GAP         = 1,
    parameter int          RESULT_WAIT = 2,
    parameter logic [19:0] LFSR_SEED   = 20'hACE15
) (
    input logic       clk,
    input logic       reset,
    loteria_if.slave  bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIN, ST_WAIT, ST_CAPTURE} state_t;
    state_t      state, state_d;
    logic [2:0]  idx, idx_d;
    logic [15:0] cnt, cnt_d;
    logic [19:0] digs, digs_d, qp_digs, lfsr;
    logic        bad, accept, last;
    logic [3:0]  num_q, num_d;
    logic        insert_q, finish_q, busy_q, done_q, win_q, err_q;
    logic [1:0]  premio_q;
    function automatic logic [3:0] reduce(input logic [3:0] n);
        return n >= 4'd10 ? n - 4'd10 : n;
    endfunction
    // ticket validation and quick-pick digit reduction from the current LFSR value
    always_comb begin
        bad = 1'b0;
        qp_digs = '0;
        for (int i = 0; i < 5; i++) begin
            bad = bad | (bus.ticket[4*i +: 4] > 4'd9);
            qp_digs[4*i +: 4] = reduce(lfsr[4*i +: 4]);
        end
    end
    assign accept = state == ST_IDLE && bus.start && (bus.quick_pick || !bad);
    assign last = idx == 3'd4;
    // free-running Galois LFSR, x^20+x^17+1; a nonzero seed keeps it off the zero state
    always_ff @(posedge clk)
        lfsr <= reset ? LFSR_SEED : {1'b0, lfsr[19:1]} ^ (lfsr[0] ? 20'h90000 : 20'h0);
    // state register plus registered outputs computed from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx <= '0;
            cnt <= '0;
            digs <= '0;
            num_q <= '0;
            insert_q <= 1'b0;
            finish_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            win_q <= 1'b0;
            premio_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            idx <= idx_d;
            cnt <= cnt_d;
            digs <= digs_d;
            num_q <= num_d;
            insert_q <= state_d == ST_SEND;
            finish_q <= state_d == ST_FIN;
            busy_q <= state_d != ST_IDLE;
            done_q <= state_d == ST_CAPTURE;
            win_q <= state_d == ST_CAPTURE ? bus.win_in : win_q;
            premio_q <= state_d == ST_CAPTURE ? bus.premio_in : premio_q;
            err_q <= state == ST_IDLE && bus.start && !bus.quick_pick && bad;
        end
    end
    // next-state: digit loop with optional gap, then finish, result wait and capture
    always_comb begin
        state_d = state;
        idx_d = idx;
        cnt_d = cnt;
        digs_d = digs;
        case (state)
            ST_IDLE: if (accept) begin
                state_d = ST_SEND;
                idx_d = '0;
                digs_d = bus.quick_pick ? qp_digs : bus.ticket;
            end
            ST_SEND: if (GAP != 0) begin
                state_d = ST_GAP;
                cnt_d = '0;
            end else begin
                state_d = last ? ST_FIN : ST_SEND;
                idx_d = last ? idx : idx + 3'd1;
            end
            ST_GAP: if (cnt == 16'(GAP - 1)) begin
                state_d = last ? ST_FIN : ST_SEND;
                idx_d = last ? idx : idx + 3'd1;
            end else cnt_d = cnt + 16'd1;
            ST_FIN: begin
                state_d = RESULT_WAIT != 0 ? ST_WAIT : ST_CAPTURE;
                cnt_d = '0;
            end
            ST_WAIT: if (cnt == 16'(RESULT_WAIT - 1)) state_d = ST_CAPTURE;
                     else cnt_d = cnt + 16'd1;
            default: state_d = ST_IDLE;
        endcase
    end
    // digit shown to the game: loaded on entry to SEND, held otherwise
    always_comb num_d = state_d == ST_SEND ? digs_d[{idx_d, 2'b00} +: 4] : num_q;
    assign bus.num = num_q;
    assign bus.insert = insert_q;
    assign bus.finish = finish_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.win_out = win_q;
    assign bus.premio_out = premio_q;
    assign bus.err_bcd = err_q;
endmodule
